inst_fetch_ctrl: RTL and testbench
==================================

Name: inst_fetch_ctrl

Overview:
- Sequences the instruction ROM for the RV64I core.
- Owns the fetch PC and drives the ROM's combinational read address every cycle.
- Captures the returned 32-bit word, paired with its PC, into a small prefetch FIFO.
- Presents instructions to decode over a valid/ready handshake; handles jump redirects (flush and re-steer) and decode back-pressure.

Parameters:
- FIFO_DEPTH, 4, prefetch entries; power of two, >= 2.
- RESET_PC, 64'h0, fetch PC after reset; must be 4-byte aligned.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- fetch_en_i  in  1  1 = allowed to issue new ROM reads
- rom_addr_o  out  64 (`ADDR_BUS_WIDTH)  byte address to ROM; ROM indexes word [63:2]
- rom_inst_i  in  32 (`INST_WIDTH)  ROM data, combinational from rom_addr_o
- jump_en_i  in  1  redirect request from execute
- jump_addr_i  in  64  redirect target
- inst_o  out  32  instruction at FIFO head
- inst_addr_o  out  64  PC of inst_o
- inst_valid_o  out  1  head entry valid
- inst_ready_i  in  1  decode accepts head
- misalign_o  out  1  one-cycle pulse: last jump target had [1:0] != 0
- fifo_cnt_o  out  log2(FIFO_DEPTH)+1  occupied entries

Behaviour:
- Reset (async, immediate on rst=1):
  - fetch_pc = RESET_PC; FIFO pointers and count = 0; misalign_o = 0.
  - Outputs: inst_valid_o = 0, inst_o = `INST_NOP (32'h0000_0013), inst_addr_o = 0, fifo_cnt_o = 0.
  - rom_addr_o = RESET_PC.
- rom_addr_o = fetch_pc, driven directly from the register (no combinational input path).
- pop = inst_valid_o & inst_ready_i.
- Write rule: wr = fetch_en_i & !jump_en_i & (count < FIFO_DEPTH | pop).
  - On wr: entry {fetch_pc, rom_inst_i} enters the tail; fetch_pc <= fetch_pc + 4.
  - fetch_pc wraps modulo 2^64.
- Output:
  - inst_valid_o = (count != 0).
  - inst_o and inst_addr_o come from the head entry when valid, otherwise NOP and 0.
- Latency: a word written in cycle N is visible at the head in cycle N+1 (no bypass). First instruction after reset release is valid one cycle after the first write cycle.
- Full: with count = FIFO_DEPTH and no pop, there is no write and fetch_pc holds. Full with a simultaneous pop writes and pops; count is unchanged.
- Empty with pop: impossible, because pop requires valid.
- Simultaneous write and pop: count unchanged; both pointers advance; pointers wrap modulo FIFO_DEPTH.
- Redirect (jump_en_i = 1) has highest priority:
  - FIFO flushed: count = 0, pointers equalised. A pop in the same cycle is treated as consumed, and all other entries are discarded.
  - No write that cycle.
  - fetch_pc <= {jump_addr_i[63:2], 2'b00}.
  - misalign_o <= (jump_addr_i[1:0] != 0) for exactly one cycle.
  - Target is written the next cycle (if fetch_en_i = 1) and is valid 2 cycles after the jump cycle.
- Back-to-back jumps: the last one wins; each jump re-flushes.
- fetch_en_i = 0: no writes, fetch_pc holds, the FIFO drains normally, and jumps are still honoured.
- inst_valid_o is never raised spuriously. Once raised, head data is stable until pop or jump.
- Reset asserted mid-stream discards all entries asynchronously; fetch restarts at RESET_PC.

Decomposition:
- defines.v (shared) gains:
  - `INST_NOP 32'h0000_0013
  - `RESET_PC
  - `FIFO_CNT_WIDTH helper
- Reuses the existing `ADDR_BUS_WIDTH and `INST_WIDTH.
- One sub-module, inst_fifo: synchronous FIFO with async active-high reset, synchronous flush input, and a 96-bit entry {pc, inst}. Ports: wr, pop, flush, head data, count.
- The PC and redirect logic stay in inst_fetch_ctrl.

Test Plan:
- ROM model: word k = 32'hA000_0000+k.
- Reset release, fetch_en = 1, ready = 1:
  - rom_addr_o steps 0, 4, 8, ...
  - First valid 1 cycle after the first write, with inst_o = A0000000, inst_addr_o = 0.
  - Thereafter one instruction per cycle; fifo_cnt_o stays 1.
- ready = 0 for 10 cycles:
  - fifo_cnt_o saturates at 4 and rom_addr_o freezes at 16.
  - The head holds A0000000 / 0 throughout.
  - After ready = 1, entries drain in order 0, 4, 8, 12, 16 with no gaps or duplicates.
- jump_en = 1, jump_addr = 64'h100 while 3 entries are queued:
  - Next cycle: fifo_cnt_o = 0, valid = 0, rom_addr_o = 0x100.
  - Following cycle: inst_o = A0000040, inst_addr_o = 0x100.
  - misalign_o stays 0.
- jump_addr = 64'h102:
  - fetch resumes at 0x100.
  - misalign_o pulses high for exactly one cycle.
- Full FIFO with a simultaneous pop: count stays 4 and the written PC is the next sequential value. Then fetch_en = 0: the FIFO drains to 0 and rom_addr_o is constant.
- rst pulsed mid-stream (asynchronously, between edges):
  - valid drops immediately; fifo_cnt_o = 0; rom_addr_o = RESET_PC.
  - Streaming restarts from A0000000.

Source files
------------

// File: rtl/inst_fetch_ctrl_pkg.sv
// Shared widths, constants and the prefetch entry type for the instruction fetch slice.
package inst_fetch_ctrl_pkg;

    localparam int ADDR_BUS_WIDTH = 64;
    localparam int INST_WIDTH     = 32;

    localparam logic [INST_WIDTH-1:0]     INST_NOP         = 32'h0000_0013;
    localparam logic [ADDR_BUS_WIDTH-1:0] RESET_PC_DEFAULT = 64'h0;

    typedef struct packed {
        logic [ADDR_BUS_WIDTH-1:0] pc;
        logic [INST_WIDTH-1:0]     inst;
    } fetch_entry_t;

    // Count field must hold the value DEPTH itself, hence one bit beyond the pointer.
    function automatic int fifo_cnt_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/inst_fetch_ctrl_fifo.sv
// Prefetch FIFO holding {pc, inst} pairs; synchronous flush, async active-high reset.
module inst_fifo
    import inst_fetch_ctrl_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int PW   = $clog2(DEPTH),
    localparam int CW   = PW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_i,
    input  fetch_entry_t  wr_data_i,
    input  logic          pop_i,
    input  logic          flush_i,
    output fetch_entry_t  head_o,
    output logic [CW-1:0] cnt_o
);

    fetch_entry_t  mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // Flush wins over everything, so a same-cycle pop or write is simply dropped.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
        end else begin
            if (wr_i) wr_ptr_d = wr_ptr_q + PW'(1);
            if (pop_i) rd_ptr_d = rd_ptr_q + PW'(1);
            case ({wr_i, pop_i})
                2'b10:   cnt_d = cnt_q + CW'(1);
                2'b01:   cnt_d = cnt_q - CW'(1);
                default: cnt_d = cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_i && !flush_i) mem_q[wr_ptr_q] <= wr_data_i;
    end

    assign head_o = mem_q[rd_ptr_q];
    assign cnt_o  = cnt_q;

endmodule

// File: rtl/inst_fetch_ctrl.sv
// Fetch PC sequencing, jump redirect and decode handshake in front of the instruction ROM.
module inst_fetch_ctrl
    import inst_fetch_ctrl_pkg::*;
#(
    parameter int                        FIFO_DEPTH = 4,
    parameter logic [ADDR_BUS_WIDTH-1:0] RESET_PC   = RESET_PC_DEFAULT,
    localparam int                       CW         = fifo_cnt_width(FIFO_DEPTH)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      fetch_en_i,
    output logic [ADDR_BUS_WIDTH-1:0] rom_addr_o,
    input  logic [INST_WIDTH-1:0]     rom_inst_i,
    input  logic                      jump_en_i,
    input  logic [ADDR_BUS_WIDTH-1:0] jump_addr_i,
    output logic [INST_WIDTH-1:0]     inst_o,
    output logic [ADDR_BUS_WIDTH-1:0] inst_addr_o,
    output logic                      inst_valid_o,
    input  logic                      inst_ready_i,
    output logic                      misalign_o,
    output logic [CW-1:0]             fifo_cnt_o
);

    logic [ADDR_BUS_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
    logic                      misalign_q, misalign_d;
    logic                      pop, wr, fifo_has_room;
    logic [CW-1:0]             cnt;
    fetch_entry_t              head, wr_entry;

    assign inst_valid_o  = (cnt != '0);
    assign pop           = inst_valid_o & inst_ready_i;
    assign fifo_has_room = (cnt < CW'(FIFO_DEPTH)) | pop;
    assign wr            = fetch_en_i & ~jump_en_i & fifo_has_room;
    assign wr_entry      = '{pc: fetch_pc_q, inst: rom_inst_i};

    // A redirect re-steers to the word-aligned target; the low bits only feed the misalign flag.
    always_comb begin
        fetch_pc_d = fetch_pc_q;
        misalign_d = 1'b0;
        if (jump_en_i) begin
            fetch_pc_d = {jump_addr_i[ADDR_BUS_WIDTH-1:2], 2'b00};
            misalign_d = (jump_addr_i[1:0] != 2'b00);
        end else if (wr) begin
            fetch_pc_d = fetch_pc_q + ADDR_BUS_WIDTH'(4);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc_q <= RESET_PC;
            misalign_q <= 1'b0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            misalign_q <= misalign_d;
        end
    end

    inst_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .wr_i     (wr),
        .wr_data_i(wr_entry),
        .pop_i    (pop),
        .flush_i  (jump_en_i),
        .head_o   (head),
        .cnt_o    (cnt)
    );

    assign rom_addr_o  = fetch_pc_q;
    assign misalign_o  = misalign_q;
    assign fifo_cnt_o  = cnt;
    assign inst_o      = inst_valid_o ? head.inst : INST_NOP;
    assign inst_addr_o = inst_valid_o ? head.pc : '0;

endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// Randomized + directed bench for inst_fetch_ctrl against a queue-based reference model.
module tb_inst_fetch_ctrl;

    localparam int DEPTH = 4;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        fetch_en = 1'b0;
    logic [63:0] rom_addr;
    logic [31:0] rom_inst;
    logic        jump_en = 1'b0;
    logic [63:0] jump_addr = '0;
    logic [31:0] inst;
    logic [63:0] inst_addr;
    logic        inst_valid;
    logic        inst_ready = 1'b0;
    logic        misalign;
    logic [2:0]  fifo_cnt;

    int total = 0;
    int bad = 0;
    bit chk_on = 1'b0;

    typedef struct {
        logic [63:0] pc;
        logic [31:0] inst;
    } model_entry_t;

    model_entry_t mq[$];
    logic [63:0]  mpc;
    logic         mmis;

    always #5 clk = ~clk;

    // ROM: word k holds A000_0000 + k
    assign rom_inst = 32'hA000_0000 + rom_addr[33:2];

    inst_fetch_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .fetch_en_i  (fetch_en),
        .rom_addr_o  (rom_addr),
        .rom_inst_i  (rom_inst),
        .jump_en_i   (jump_en),
        .jump_addr_i (jump_addr),
        .inst_o      (inst),
        .inst_addr_o (inst_addr),
        .inst_valid_o(inst_valid),
        .inst_ready_i(inst_ready),
        .misalign_o  (misalign),
        .fifo_cnt_o  (fifo_cnt)
    );

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a plain queue of fetched {pc, inst} pairs advanced on each clock edge.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mq.delete();
            mpc  = 64'h0;
            mmis = 1'b0;
        end else begin
            bit vld, pp, dowr;
            vld = (mq.size() != 0);
            pp  = vld && inst_ready;
            if (jump_en) begin
                mq.delete();
                mpc  = {jump_addr[63:2], 2'b00};
                mmis = (jump_addr[1:0] != 2'b00);
            end else begin
                mmis = 1'b0;
                dowr = fetch_en && ((mq.size() < DEPTH) || pp);
                if (pp) void'(mq.pop_front());
                if (dowr) begin
                    mq.push_back('{pc: mpc, inst: 32'hA000_0000 + mpc[33:2]});
                    mpc = mpc + 64'd4;
                end
            end
        end
    end

    // Compare process: every negedge, every output against the model.
    always @(negedge clk) begin
        if (chk_on) begin
            bit v;
            v = (mq.size() != 0);
            checkOutput("model_valid", {63'd0, inst_valid}, {63'd0, v});
            checkOutput("model_cnt", {61'd0, fifo_cnt}, 64'(mq.size()));
            checkOutput("model_rom_addr", rom_addr, mpc);
            checkOutput("model_misalign", {63'd0, misalign}, {63'd0, mmis});
            checkOutput("model_inst", {32'd0, inst}, {32'd0, v ? mq[0].inst : NOP});
            checkOutput("model_inst_addr", inst_addr, v ? mq[0].pc : 64'h0);
        end
    end

    task automatic applyStimulus(input bit en, input bit rdy, input bit jmp, input logic [63:0] ja);
        fetch_en   = en;
        inst_ready = rdy;
        jump_en    = jmp;
        jump_addr  = ja;
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        logic [63:0] frozen;
        applyStimulus(0, 0, 0, 64'h0);
        #12;
        @(negedge clk);
        checkOutput("reset_valid", {63'd0, inst_valid}, 64'd0);
        checkOutput("reset_inst", {32'd0, inst}, {32'd0, NOP});
        checkOutput("reset_inst_addr", inst_addr, 64'h0);
        checkOutput("reset_cnt", {61'd0, fifo_cnt}, 64'd0);
        checkOutput("reset_rom_addr", rom_addr, 64'h0);
        checkOutput("reset_misalign", {63'd0, misalign}, 64'd0);

        @(posedge clk);
        #1;
        rst = 1'b0;
        chk_on = 1'b1;
        applyStimulus(1, 0, 0, 64'h0);
        tick(1);
        @(negedge clk);
        checkOutput("first_valid", {63'd0, inst_valid}, 64'd1);
        checkOutput("first_inst", {32'd0, inst}, 64'hA000_0000);
        checkOutput("first_addr", inst_addr, 64'h0);
        checkOutput("first_rom_addr", rom_addr, 64'h4);
        tick(9);
        @(negedge clk);
        checkOutput("full_cnt", {61'd0, fifo_cnt}, 64'd4);
        checkOutput("full_rom_addr", rom_addr, 64'h10);
        checkOutput("full_head", {32'd0, inst}, 64'hA000_0000);

        // one pop with fetch off leaves three entries queued
        applyStimulus(0, 1, 0, 64'h0);
        tick(1);
        applyStimulus(1, 0, 1, 64'h100);
        tick(1);
        @(negedge clk);
        checkOutput("jump_cnt", {61'd0, fifo_cnt}, 64'd0);
        checkOutput("jump_valid", {63'd0, inst_valid}, 64'd0);
        checkOutput("jump_rom_addr", rom_addr, 64'h100);
        checkOutput("jump_misalign", {63'd0, misalign}, 64'd0);
        applyStimulus(1, 1, 0, 64'h0);
        tick(1);
        @(negedge clk);
        checkOutput("target_inst", {32'd0, inst}, 64'hA000_0040);
        checkOutput("target_addr", inst_addr, 64'h100);

        applyStimulus(1, 1, 1, 64'h102);
        tick(1);
        @(negedge clk);
        checkOutput("mis_pulse", {63'd0, misalign}, 64'd1);
        checkOutput("mis_rom_addr", rom_addr, 64'h100);
        applyStimulus(1, 1, 0, 64'h0);
        tick(1);
        @(negedge clk);
        checkOutput("mis_clear", {63'd0, misalign}, 64'd0);

        for (int i = 0; i < 400; i++) begin
            logic [63:0] ja;
            int sel;
            sel = int'($urandom_range(0, 3));
            case (sel)
                0: ja = {32'd0, $urandom()};
                1: ja = 64'hFFFF_FFFF_FFFF_FFF0 | 64'($urandom_range(0, 15));
                2: ja = {52'd0, 12'($urandom())};
                default: ja = {$urandom(), $urandom()};
            endcase
            applyStimulus($urandom_range(0, 9) != 0, $urandom_range(0, 2) != 0,
                          $urandom_range(0, 15) == 0, ja);
            tick(1);
        end

        applyStimulus(1, 0, 0, 64'h0);
        tick(6);
        applyStimulus(1, 1, 0, 64'h0);
        tick(1);
        @(negedge clk);
        checkOutput("full_pop_cnt", {61'd0, fifo_cnt}, 64'd4);
        applyStimulus(0, 1, 0, 64'h0);
        frozen = rom_addr;
        tick(6);
        @(negedge clk);
        checkOutput("drain_cnt", {61'd0, fifo_cnt}, 64'd0);
        checkOutput("drain_rom_addr", rom_addr, frozen);

        applyStimulus(1, 1, 0, 64'h0);
        tick(5);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("async_valid", {63'd0, inst_valid}, 64'd0);
        checkOutput("async_cnt", {61'd0, fifo_cnt}, 64'd0);
        checkOutput("async_rom_addr", rom_addr, 64'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        tick(1);
        @(negedge clk);
        checkOutput("restart_inst", {32'd0, inst}, 64'hA000_0000);
        checkOutput("restart_addr", inst_addr, 64'h0);
        tick(20);
        chk_on = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
